fetch_unit: RTL

Instruction fetch stage of the single-cycle RV32I core. It holds the program counter, requests instruction words from instruction memory, and presents one registered instruction at a time, with its PC, to the decode/control stage through a valid/ready handshake. Branch and jump targets arrive on a redirect port, which flushes the held instruction. A misaligned target raises a sticky fault that stops fetching until reset.

---
 rtl/fetch_unit.sv | 143 ++++++++++++++
 1 files changed

// File: rtl/fetch_unit.sv
// fetch_unit -- instruction fetch stage of the single-cycle RV32I core.
//
// Holds the program counter, fetches one word per cycle from instruction
// memory and hands it, with its PC, to decode over a valid/ready handshake.
// A redirect loads a new PC and flushes the held instruction. A redirect
// target that is not word-aligned latches a sticky fault and stops fetching
// until reset.
//
// Ports:
//   clk, rst       clock; asynchronous active-high reset
//   imem_req       fetch request for imem_addr this cycle
//   imem_addr      word address being fetched (always pc)
//   imem_ack       imem_rdata valid for imem_addr this cycle
//   imem_rdata     instruction word from memory
//   instr          registered instruction for decode
//   instr_pc       PC of instr
//   instr_valid    instr/instr_pc hold an unconsumed instruction
//   instr_ready    decode consumes instr this cycle when instr_valid=1
//   redirect       load redirect_pc and flush the held instruction
//   redirect_pc    branch/jump target
//   misaligned     sticky fault: redirect target not word-aligned
//   instr_count    number of handovers (valid & ready), wraps mod 2^32
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:0] instr,
  output logic [31:0] instr_pc,
  output logic        instr_valid,
  input  logic        instr_ready,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        misaligned,
  output logic [31:0] instr_count
);

  localparam logic [31:0] NOP = 32'h0000_0013;

  typedef enum logic [1:0] {
    FETCH = 2'd0,
    HOLD  = 2'd1,
    HALT  = 2'd2
  } state_t;

  state_t      state;
  logic [31:0] pc;

  // Sequential PC step; wraps naturally at the top of the address space.
  function automatic logic [31:0] pc_step(input logic [31:0] cur);
    return cur + 32'd4;
  endfunction

  function automatic logic word_aligned(input logic [31:0] addr);
    return (addr[1:0] == 2'b00);
  endfunction

  assign imem_addr = pc;

  // A request goes out whenever the holding register is empty or being
  // emptied this cycle. Redirect suppresses it so a stale ack can never be
  // captured. rst gates it because the reset state is FETCH.
  assign imem_req = !rst && !redirect &&
                    ((state == FETCH) || ((state == HOLD) && instr_ready));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= FETCH;
      pc          <= RESET_PC;
      instr       <= NOP;
      instr_pc    <= RESET_PC;
      instr_valid <= 1'b0;
      misaligned  <= 1'b0;
      instr_count <= 32'd0;
    end else begin
      case (state)
        FETCH: begin
          if (redirect) begin
            instr_valid <= 1'b0;
            if (word_aligned(redirect_pc)) begin
              pc    <= redirect_pc;
              state <= FETCH;
            end else begin
              misaligned <= 1'b1;
              state      <= HALT;
            end
          end else if (imem_ack) begin
            instr       <= imem_rdata;
            instr_pc    <= pc;
            pc          <= pc_step(pc);
            instr_valid <= 1'b1;
            state       <= HOLD;
          end
        end

        HOLD: begin
          // The handover still counts when a redirect flushes in the
          // same cycle; the flush only affects what follows.
          if (instr_ready) begin
            instr_count <= instr_count + 32'd1;
          end
          if (redirect) begin
            instr_valid <= 1'b0;
            if (word_aligned(redirect_pc)) begin
              pc    <= redirect_pc;
              state <= FETCH;
            end else begin
              misaligned <= 1'b1;
              state      <= HALT;
            end
          end else if (instr_ready) begin
            if (imem_ack) begin
              instr    <= imem_rdata;
              instr_pc <= pc;
              pc       <= pc_step(pc);
              state    <= HOLD;
            end else begin
              instr_valid <= 1'b0;
              state       <= FETCH;
            end
          end
        end

        HALT: begin
          // Only reset leaves this state; redirects are ignored.
          instr_valid <= 1'b0;
          misaligned  <= 1'b1;
          state       <= HALT;
        end

        default: begin
          instr_valid <= 1'b0;
          state       <= FETCH;
        end
      endcase
    end
  end

endmodule
